// File: rtl/sram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// sram_burst_ctrl
//
// Bridges a simple valid/ready host port to an asynchronous SRAM with a fixed
// number of wait cycles per word. A write is a single word. A read is a burst
// of BURST_LEN words that starts at the requested word and wraps inside the
// aligned line (critical word first). If an address is outside the SRAM window,
// the controller makes no SRAM access and returns a one-word error response.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   req_valid     host request present
//   req_ready     request accepted on this cycle (high only while idle)
//   req_write     1 = single-word write, 0 = burst read
//   req_addr      host byte address (bits [1:0] ignored)
//   req_wdata     write data
//   rsp_valid     one-cycle pulse per read word or write completion
//   rsp_data      read word; holds its value between read responses
//   rsp_last      last response of the transaction
//   rsp_err       address outside the SRAM window
//   SRAM_DQ       bidirectional SRAM data bus (driven only while writing)
//   SRAM_ADDR     SRAM word address, stable for the whole word access
//   SRAM_WE_N     active-low write enable
//   SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N   tied low
// -----------------------------------------------------------------------------
module sram_burst_ctrl #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned SRAM_AW     = 17,
   parameter int unsigned WAIT_CYCLES = 4,
   parameter int unsigned BURST_LEN   = 2,
   parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_write,
   input  logic [31:0]        req_addr,
   input  logic [DATA_W-1:0]  req_wdata,
   output logic               rsp_valid,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               rsp_last,
   output logic               rsp_err,
   inout  wire  [DATA_W-1:0]  SRAM_DQ,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_WE_N,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_OE_N
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ERR    = 2'd2
   } state_t;

   // Last value of the wait counter, last word number of a burst, and the mask
   // that selects the in-line word bits (zero when BURST_LEN is 1).
   localparam logic [3:0]         CNT_LAST  = 4'(WAIT_CYCLES);
   localparam logic [3:0]         WORD_LAST = 4'(BURST_LEN - 1);
   localparam logic [SRAM_AW-1:0] LINE_MASK = SRAM_AW'(BURST_LEN - 1);

   state_t              state_r;
   state_t              state_nxt_s;

   logic [3:0]          cnt_r;
   logic [3:0]          cnt_nxt_s;
   logic [3:0]          word_r;
   logic [3:0]          word_nxt_s;
   logic [3:0]          word_inc_s;
   logic                write_r;
   logic [SRAM_AW-1:0]  base_r;
   logic [DATA_W-1:0]   wdata_r;

   logic                ready_r;
   logic                ready_nxt_s;
   logic                rsp_valid_r;
   logic                rsp_valid_nxt_s;
   logic                rsp_last_r;
   logic                rsp_last_nxt_s;
   logic                rsp_err_r;
   logic                rsp_err_nxt_s;
   logic [DATA_W-1:0]   rsp_data_r;
   logic                we_n_r;
   logic                we_n_nxt_s;
   logic [SRAM_AW-1:0]  sram_addr_r;
   logic [SRAM_AW-1:0]  sram_addr_nxt_s;

   logic                capture_s;
   logic                sample_s;
   logic                cnt_last_s;
   logic                word_last_s;

   logic [31:0]         addr_aligned_s;
   logic [31:0]         diff_s;
   logic [29:0]         idx_s;
   logic                range_err_s;
   logic [SRAM_AW-1:0]  next_word_addr_s;
   logic                unused_s;

   // Host address decode. The subtraction wraps in 32 bits, so addresses below
   // the base are caught by the explicit compare rather than by the index test.
   assign addr_aligned_s = {req_addr[31:2], 2'b00};
   assign diff_s         = addr_aligned_s - BASE_ADDR;
   assign idx_s          = diff_s[31:2];
   assign range_err_s    = (addr_aligned_s < BASE_ADDR) || ((idx_s >> SRAM_AW) != 30'd0);
   assign unused_s       = ^{req_addr[1:0], diff_s[1:0]};

   assign cnt_last_s     = (cnt_r == CNT_LAST);
   assign word_last_s    = (word_r == WORD_LAST);
   assign word_inc_s     = word_r + 4'd1;

   // Wrapped burst address: the line part of the start index is kept, and the
   // in-line part advances modulo the line length.
   assign next_word_addr_s = (base_r & ~LINE_MASK)
                           | ((base_r + SRAM_AW'(word_inc_s)) & LINE_MASK);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_valid) begin
               state_nxt_s = range_err_s ? ST_ERR : ST_ACCESS;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            // Leave on the last wait cycle of a write or of the last read word,
            // so that the final response and req_ready appear together.
            if (cnt_last_s && (write_r || word_last_s)) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_ACCESS;
            end
         end
         ST_ERR: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output decode: values that the output registers take on the next edge.
   always_comb begin
      cnt_nxt_s       = cnt_r;
      word_nxt_s      = word_r;
      sram_addr_nxt_s = sram_addr_r;
      we_n_nxt_s      = 1'b1;
      rsp_valid_nxt_s = 1'b0;
      rsp_last_nxt_s  = 1'b0;
      rsp_err_nxt_s   = 1'b0;
      capture_s       = 1'b0;
      sample_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_valid) begin
               capture_s  = 1'b1;
               cnt_nxt_s  = 4'd0;
               word_nxt_s = 4'd0;
               if (range_err_s) begin
                  sram_addr_nxt_s = sram_addr_r;
                  we_n_nxt_s      = 1'b1;
               end else begin
                  sram_addr_nxt_s = idx_s[SRAM_AW-1:0];
                  we_n_nxt_s      = ~req_write;
               end
            end else begin
               capture_s = 1'b0;
            end
         end
         ST_ACCESS: begin
            if (cnt_last_s) begin
               cnt_nxt_s       = 4'd0;
               rsp_valid_nxt_s = 1'b1;
               if (write_r) begin
                  rsp_last_nxt_s = 1'b1;
               end else begin
                  sample_s = 1'b1;
                  if (word_last_s) begin
                     rsp_last_nxt_s = 1'b1;
                  end else begin
                     word_nxt_s      = word_inc_s;
                     sram_addr_nxt_s = next_word_addr_s;
                  end
               end
            end else begin
               cnt_nxt_s  = cnt_r + 4'd1;
               we_n_nxt_s = ~write_r;
            end
         end
         ST_ERR: begin
            rsp_valid_nxt_s = 1'b1;
            rsp_last_nxt_s  = 1'b1;
            rsp_err_nxt_s   = 1'b1;
         end
         default: begin
            we_n_nxt_s = 1'b1;
         end
      endcase
   end

   assign ready_nxt_s = (state_nxt_s == ST_IDLE);

   // Output and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r       <= 4'd0;
         word_r      <= 4'd0;
         write_r     <= 1'b0;
         base_r      <= '0;
         wdata_r     <= '0;
         ready_r     <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_last_r  <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_data_r  <= '0;
         we_n_r      <= 1'b1;
         sram_addr_r <= '0;
      end else begin
         cnt_r       <= cnt_nxt_s;
         word_r      <= word_nxt_s;
         ready_r     <= ready_nxt_s;
         rsp_valid_r <= rsp_valid_nxt_s;
         rsp_last_r  <= rsp_last_nxt_s;
         rsp_err_r   <= rsp_err_nxt_s;
         we_n_r      <= we_n_nxt_s;
         sram_addr_r <= sram_addr_nxt_s;
         if (capture_s) begin
            write_r <= req_write;
            wdata_r <= req_wdata;
            base_r  <= idx_s[SRAM_AW-1:0];
         end else begin
            write_r <= write_r;
            wdata_r <= wdata_r;
            base_r  <= base_r;
         end
         if (sample_s) begin
            rsp_data_r <= SRAM_DQ;
         end else begin
            rsp_data_r <= rsp_data_r;
         end
      end
   end

   // The bus is released whenever write enable is inactive, including the
   // instant an asynchronous reset forces WE_N high.
   assign SRAM_DQ   = we_n_r ? {DATA_W{1'bz}} : wdata_r;
   assign SRAM_ADDR = sram_addr_r;
   assign SRAM_WE_N = we_n_r;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;

   assign req_ready = ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = rsp_data_r;
   assign rsp_last  = rsp_last_r;
   assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_burst_ctrl
//
// Two controllers share the host stimulus: dut_a with default parameters and
// dut_b with WAIT_CYCLES=1, BURST_LEN=4. sel picks which one sees req_valid
// and whose outputs are observed. Each has a 256-word SRAM model. Expected
// timing, addresses and data come from a cycle-numbered transaction model
// computed with plain arithmetic on the request.
// -----------------------------------------------------------------------------
module tb_sram_burst_ctrl;

   localparam int N = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        mem_clr = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;

   logic        a_valid_in, b_valid_in;
   logic        a_ready, b_ready, a_rvalid, b_rvalid, a_last, b_last, a_err, b_err;
   logic [31:0] a_data, b_data;
   wire  [31:0] a_dq, b_dq;
   logic [16:0] a_addr, b_addr;
   logic        a_we_n, b_we_n;
   logic        a_ub, a_lb, a_ce, a_oe, b_ub, b_lb, b_ce, b_oe;

   int tests = 0;
   int fails = 0;

   logic [31:0] ref_mem [2][256];
   logic [16:0] last_addr [2];
   logic [31:0] exp_data [2];

   always #5 clk = ~clk;

   assign a_valid_in = req_valid & ~sel;
   assign b_valid_in = req_valid & sel;

   sram_burst_ctrl dut_a (
      .clk(clk), .rst(rst), .req_valid(a_valid_in), .req_ready(a_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(a_rvalid), .rsp_data(a_data), .rsp_last(a_last), .rsp_err(a_err),
      .SRAM_DQ(a_dq), .SRAM_ADDR(a_addr), .SRAM_WE_N(a_we_n),
      .SRAM_UB_N(a_ub), .SRAM_LB_N(a_lb), .SRAM_CE_N(a_ce), .SRAM_OE_N(a_oe));

   sram_burst_ctrl #(.WAIT_CYCLES(1), .BURST_LEN(4)) dut_b (
      .clk(clk), .rst(rst), .req_valid(b_valid_in), .req_ready(b_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(b_rvalid), .rsp_data(b_data), .rsp_last(b_last), .rsp_err(b_err),
      .SRAM_DQ(b_dq), .SRAM_ADDR(b_addr), .SRAM_WE_N(b_we_n),
      .SRAM_UB_N(b_ub), .SRAM_LB_N(b_lb), .SRAM_CE_N(b_ce), .SRAM_OE_N(b_oe));

   // Initial SRAM contents (words 2 and 3 hold 0xA and 0xB).
   function automatic logic [31:0] init_word(input int i);
      if (i == 2) return 32'h0000_000A;
      else if (i == 3) return 32'h0000_000B;
      else return 32'hC0DE_0000 + 32'(i * 7);
   endfunction

   // SRAM models: written words overlay the initial contents.
   logic [31:0]  a_mem [256];
   logic [31:0]  b_mem [256];
   logic [255:0] a_wr, b_wr;
   logic [31:0]  a_rd, b_rd;
   assign a_rd = a_wr[a_addr[7:0]] ? a_mem[a_addr[7:0]] : init_word(int'(a_addr[7:0]));
   assign b_rd = b_wr[b_addr[7:0]] ? b_mem[b_addr[7:0]] : init_word(int'(b_addr[7:0]));
   assign a_dq = a_we_n ? a_rd : {32{1'bz}};
   assign b_dq = b_we_n ? b_rd : {32{1'bz}};

   always @(posedge clk) begin
      if (mem_clr) begin
         a_wr <= '0;
         b_wr <= '0;
      end else begin
         if (a_we_n == 1'b0) begin
            a_mem[a_addr[7:0]] <= a_dq;
            a_wr[a_addr[7:0]]  <= 1'b1;
         end
         if (b_we_n == 1'b0) begin
            b_mem[b_addr[7:0]] <= b_dq;
            b_wr[b_addr[7:0]]  <= 1'b1;
         end
      end
   end

   logic        obs_ready, obs_valid, obs_last, obs_err, obs_we_n;
   logic [31:0] obs_data, obs_dq;
   logic [16:0] obs_addr;
   assign obs_ready = sel ? b_ready  : a_ready;
   assign obs_valid = sel ? b_rvalid : a_rvalid;
   assign obs_last  = sel ? b_last   : a_last;
   assign obs_err   = sel ? b_err    : a_err;
   assign obs_we_n  = sel ? b_we_n   : a_we_n;
   assign obs_data  = sel ? b_data   : a_data;
   assign obs_dq    = sel ? b_dq     : a_dq;
   assign obs_addr  = sel ? b_addr   : a_addr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Word index of burst word k: start of the aligned line plus wrapped offset.
   function automatic logic [31:0] word_at(input logic [31:0] idx, input int k, input int bl);
      logic [31:0] line;
      line = (idx / 32'(bl)) * 32'(bl);
      return line + ((idx + 32'(k)) % 32'(bl));
   endfunction

   task automatic idle(input int n);
      int s;
      s = sel ? 1 : 0;
      req_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_ready", obs_ready, 1);
         chk("idle_valid", obs_valid, 0);
         chk("idle_we_n", obs_we_n, 1);
         chk("idle_addr", obs_addr, last_addr[s]);
      end
   endtask

   // Runs one transaction starting at its handshake cycle (cycle 0) and
   // returns in the cycle of its final response. The next request, if any,
   // is held on the port throughout, so it is accepted in that final cycle.
   task automatic do_txn(input int w, input int bl, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input bit nv, input bit nw,
                         input logic [31:0] na, input logic [31:0] nd);
      logic [31:0] aligned, idx, wi;
      bit          err;
      int          ncyc, k, j, s;
      s = sel ? 1 : 0;
      chk("ready_c0", obs_ready, 1);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
      aligned = {addr[31:2], 2'b00};
      idx     = (aligned - 32'd1024) >> 2;
      err     = (aligned < 32'd1024) || (idx >= 32'h0002_0000);
      ncyc    = err ? 2 : (wr ? w + 2 : bl * (w + 1) + 1);
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         chk("ready", obs_ready, (c == ncyc));
         if (err) begin
            chk("err_we_n", obs_we_n, 1);
            chk("err_addr", obs_addr, last_addr[s]);
            chk("err_valid", obs_valid, (c == 2));
            if (c == 2) begin
               chk("err_flag", obs_err, 1);
               chk("err_last", obs_last, 1);
            end
         end else if (wr) begin
            chk("wr_we_n", obs_we_n, (c <= w + 1) ? 0 : 1);
            if (c <= w + 1) begin
               chk("wr_addr", obs_addr, idx[16:0]);
               chk("wr_dq", obs_dq, wd);
            end
            chk("wr_valid", obs_valid, (c == w + 2));
            if (c == w + 2) begin
               chk("wr_last", obs_last, 1);
               chk("wr_err", obs_err, 0);
            end
         end else begin
            chk("rd_we_n", obs_we_n, 1);
            if (c <= bl * (w + 1)) begin
               k = (c - 1) / (w + 1);
               chk("rd_addr", obs_addr, word_at(idx, k, bl));
            end
            if (c >= w + 2 && (c - 1) % (w + 1) == 0) begin
               j  = (c - 1) / (w + 1) - 1;
               wi = word_at(idx, j, bl);
               exp_data[s] = ref_mem[s][wi[7:0]];
               chk("rd_valid", obs_valid, 1);
               chk("rd_last", obs_last, (j == bl - 1));
               chk("rd_err", obs_err, 0);
            end else begin
               chk("rd_valid", obs_valid, 0);
            end
         end
         chk("rsp_data", obs_data, exp_data[s]);
         if (nv) begin
            req_valid = 1'b1; req_write = nw; req_addr = na; req_wdata = nd;
         end else begin
            req_valid = 1'b0; req_write = 1'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
         end
      end
      if (!err) begin
         if (wr) begin
            ref_mem[s][idx[7:0]] = wd;
            last_addr[s] = idx[16:0];
         end else begin
            wi = word_at(idx, bl - 1, bl);
            last_addr[s] = wi[16:0];
         end
      end
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
         case ($urandom_range(0, 3))
            0: return 32'h0000_03FC;
            1: return 32'h0000_0000;
            2: return 32'hFFFF_FFF0;
            default: return 32'h0008_0400;
         endcase
      end
      return 32'd1024 + 32'($urandom_range(0, 255)) * 32'd4 + 32'($urandom_range(0, 3));
   endfunction

   bit          tw [N + 1];
   bit          tc [N + 1];
   logic [31:0] ta [N + 1];
   logic [31:0] td [N + 1];

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 256; i++) ref_mem[s][i] = init_word(i);
         last_addr[s] = 17'd0;
         exp_data[s]  = 32'd0;
      end

      // Reset values on both instances.
      @(negedge clk); @(negedge clk);
      chk("rst_a_ready", a_ready, 1);     chk("rst_b_ready", b_ready, 1);
      chk("rst_a_valid", a_rvalid, 0);    chk("rst_b_valid", b_rvalid, 0);
      chk("rst_a_last", a_last, 0);       chk("rst_a_err", a_err, 0);
      chk("rst_a_data", a_data, 0);       chk("rst_b_data", b_data, 0);
      chk("rst_a_we_n", a_we_n, 1);       chk("rst_b_we_n", b_we_n, 1);
      chk("rst_a_addr", a_addr, 0);       chk("rst_b_addr", b_addr, 0);
      chk("tied_a", {a_ub, a_lb, a_ce, a_oe}, 0);
      chk("tied_b", {b_ub, b_lb, b_ce, b_oe}, 0);
      rst = 1'b0; mem_clr = 1'b0;
      idle(2);

      // Directed: write, read with wrap, below-base and other range errors.
      do_txn(4, 2, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 32'd0);
      idle(1);
      do_txn(4, 2, 1'b0, 32'h0000_040C, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      idle(1);
      do_txn(4, 2, 1'b0, 32'h0000_03FC, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      do_txn(4, 2, 1'b0, 32'h0000_03FF, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      do_txn(4, 2, 1'b1, 32'hFFFF_FFFC, 32'h1111_1111, 1'b0, 1'b0, 32'd0, 32'd0);
      do_txn(4, 2, 1'b0, 32'h0008_0400, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      do_txn(4, 2, 1'b0, 32'h0008_03FC, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      idle(1);

      // Back-to-back: read held during a busy write, accepted in its last cycle.
      do_txn(4, 2, 1'b1, 32'h0000_0484, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0000_0484, 32'd0);
      do_txn(4, 2, 1'b0, 32'h0000_0484, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      idle(1);

      // Randomised sequence, sometimes chained.
      for (int i = 0; i <= N; i++) begin
         tw[i] = 1'($urandom);
         ta[i] = rand_addr();
         td[i] = $urandom;
         tc[i] = ($urandom_range(0, 2) == 0);
      end
      for (int i = 0; i < N; i++) begin
         do_txn(4, 2, tw[i], ta[i], td[i], tc[i], tw[i + 1], ta[i + 1], td[i + 1]);
         if (!tc[i]) idle($urandom_range(0, 2));
      end
      idle(1);

      // Reset in cycle 3 of a write: bus released at once, no response after.
      chk("rstw_ready_c0", a_ready, 1);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_04A0; req_wdata = 32'h1234_5678;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk("rstw_we_n", a_we_n, 0);
         req_valid = 1'b0;
      end
      rst = 1'b1;
      #1;
      chk("rstw_we_n_async", a_we_n, 1);
      chk("rstw_ready_async", a_ready, 1);
      chk("rstw_valid_async", a_rvalid, 0);
      chk("rstw_addr_async", a_addr, 0);
      chk("rstw_data_async", a_data, 0);
      // The SRAM already saw WE_N low across two edges before the reset.
      ref_mem[0][40] = 32'h1234_5678;
      for (int s = 0; s < 2; s++) begin
         last_addr[s] = 17'd0;
         exp_data[s]  = 32'd0;
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      idle(7);
      do_txn(4, 2, 1'b1, 32'h0000_04A4, 32'h0BAD_F00D, 1'b0, 1'b0, 32'd0, 32'd0);
      do_txn(4, 2, 1'b0, 32'h0000_04A4, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      idle(1);

      // Second instance: WAIT_CYCLES=1, BURST_LEN=4.
      sel = 1'b1;
      idle(1);
      do_txn(1, 4, 1'b0, 32'h0000_0418, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      idle(1);
      do_txn(1, 4, 1'b1, 32'h0000_0424, 32'h5555_AAAA, 1'b1, 1'b0, 32'h0000_0428, 32'd0);
      do_txn(1, 4, 1'b0, 32'h0000_0428, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < 12; i++) begin
         do_txn(1, 4, tw[i], ta[i], td[i], tc[i], tw[i + 1], ta[i + 1], td[i + 1]);
         if (!tc[i]) idle($urandom_range(0, 2));
      end
      idle(1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
